// File: rtl/config_sequence_detector.sv
// ---------------------------------------------------------------------------
// config_sequence_detector
//
// Programmable Moore sequence detector. A sequence of up to DEPTH symbols,
// each W bits wide, is held in registers together with its active length
// LEN. The progress state k counts how many leading symbols of the sequence
// have been seen in a row on the qualified input stream; k == LEN is the
// match state. Every entry into the match state bumps a saturating match
// counter, and a sticky overflow flag records matches lost to saturation.
//
// Ports
//   clock        in   1            single clock, all state changes on posedge
//   reset_       in   1            asynchronous active-low reset
//   x            in   W            incoming symbol
//   valid        in   1            qualifies x
//   prog_we      in   1            write prog_sym into sequence slot prog_idx
//   prog_idx     in   clog2(DEPTH) slot index for the symbol write
//   prog_sym     in   W            symbol to write
//   len_we       in   1            write prog_len into the length register
//   prog_len     in   clog2(DEPTH+1) requested sequence length
//   clear        in   1            synchronous clear of match_count and ovf
//   z            out  1            match flag, high while k == LEN
//   level        out  clog2(DEPTH+1) current progress state k
//   match_count  out  CNT_W        saturating number of matches
//   ovf          out  1            sticky: match seen with match_count full
// ---------------------------------------------------------------------------
module config_sequence_detector #(
    parameter int                    W        = 2,
    parameter int                    DEPTH    = 4,
    parameter int                    CNT_W    = 8,
    parameter logic [DEPTH*W-1:0]    INIT_SEQ = 8'b00_10_01_11,
    parameter int                    INIT_LEN = 3,
    // Derived widths; not meant to be overridden.
    parameter int                    IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int                    LEN_W    = $clog2(DEPTH + 1)
) (
    input  logic              clock,
    input  logic              reset_,
    input  logic [W-1:0]      x,
    input  logic              valid,
    input  logic              prog_we,
    input  logic [IDX_W-1:0]  prog_idx,
    input  logic [W-1:0]      prog_sym,
    input  logic              len_we,
    input  logic [LEN_W-1:0]  prog_len,
    input  logic              clear,
    output logic              z,
    output logic [LEN_W-1:0]  level,
    output logic [CNT_W-1:0]  match_count,
    output logic              ovf
);

    localparam logic [LEN_W-1:0] MAX_LEN   = LEN_W'(DEPTH);
    localparam logic [LEN_W-1:0] RESET_LEN = LEN_W'(INIT_LEN);

    // -----------------------------------------------------------------------
    // Helper functions
    // -----------------------------------------------------------------------

    // New length register value for a len_we strobe: zero is not a usable
    // length and leaves the register alone, oversized requests clamp.
    function automatic logic [LEN_W-1:0] clamp_len(
        input logic [LEN_W-1:0] req,
        input logic [LEN_W-1:0] cur
    );
        logic [LEN_W-1:0] res;
        if (req == '0) begin
            res = cur;
        end else if (req > MAX_LEN) begin
            res = MAX_LEN;
        end else begin
            res = req;
        end
        return res;
    endfunction

    // Saturating increment of the match counter.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] res;
        if (&v) begin
            res = v;
        end else begin
            res = v + CNT_W'(1);
        end
        return res;
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [W-1:0]      seq [DEPTH];
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  k;

    // -----------------------------------------------------------------------
    // Next-state decode
    // -----------------------------------------------------------------------
    logic              prog_any;
    logic [W-1:0]      sym_at_k;
    logic              advance;
    logic              restart;
    logic [LEN_W-1:0]  k_next;
    logic              hit;

    always_comb begin
        prog_any = prog_we | len_we;

        // When k == DEPTH the low bits alias slot 0; advance is gated by
        // k < len_q (len_q <= DEPTH), so that aliased value is never used.
        sym_at_k = seq[k[IDX_W-1:0]];
        advance  = (k < len_q) && (x == sym_at_k);
        restart  = (x == seq[0]);

        k_next = k;
        if (prog_any) begin
            // Any programming strobe drops progress; the symbol is discarded.
            k_next = '0;
        end else if (valid) begin
            if (advance) begin
                k_next = k + LEN_W'(1);
            end else if (restart) begin
                k_next = LEN_W'(1);
            end else begin
                k_next = '0;
            end
        end

        hit = valid && !prog_any && (k_next == len_q);
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            k           <= '0;
            z           <= 1'b0;
            len_q       <= RESET_LEN;
            match_count <= '0;
            ovf         <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                seq[i] <= INIT_SEQ[i*W +: W];
            end
        end else begin
            k <= k_next;
            // Registered copy of (k == LEN) so z carries no path from x/valid.
            // A len_we forces k to 0 and the stored length is never 0, so
            // comparing against the old length is safe here.
            z <= !prog_any && (k_next == len_q);

            if (prog_we && (int'(prog_idx) < DEPTH)) begin
                seq[prog_idx] <= prog_sym;
            end
            if (len_we) begin
                len_q <= clamp_len(prog_len, len_q);
            end

            // Clear has priority over a simultaneous match.
            if (clear) begin
                match_count <= '0;
                ovf         <= 1'b0;
            end else if (hit) begin
                if (&match_count) begin
                    ovf <= 1'b1;
                end
                match_count <= sat_inc(match_count);
            end
        end
    end

    assign level = k;

endmodule

// File: tb/tb_config_sequence_detector.sv
// ---------------------------------------------------------------------------
// tb_config_sequence_detector
//
// Directed bench for config_sequence_detector with default parameters.
// The driver pushes the hand-computed post-edge outputs into a scoreboard
// queue as it applies each vector; a monitor pops and compares shortly after
// each rising edge. Reset behaviour is checked directly by the main thread.
// ---------------------------------------------------------------------------
module tb_config_sequence_detector;

    logic        clock;
    logic        reset_;
    logic [1:0]  x;
    logic        valid;
    logic        prog_we;
    logic [1:0]  prog_idx;
    logic [1:0]  prog_sym;
    logic        len_we;
    logic [2:0]  prog_len;
    logic        clear;
    logic        z;
    logic [2:0]  level;
    logic [7:0]  match_count;
    logic        ovf;

    config_sequence_detector dut (
        .clock       (clock),
        .reset_      (reset_),
        .x           (x),
        .valid       (valid),
        .prog_we     (prog_we),
        .prog_idx    (prog_idx),
        .prog_sym    (prog_sym),
        .len_we      (len_we),
        .prog_len    (prog_len),
        .clear       (clear),
        .z           (z),
        .level       (level),
        .match_count (match_count),
        .ovf         (ovf)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [2:0] lvl;
        logic       zz;
        logic [7:0] cnt;
        logic       ov;
        int         id;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   step_id  = 0;

    task automatic chk(input string nm, input int id, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s (vector %0d): got %0d, expected %0d", nm, id, act, exp);
        end
    endtask

    // Monitor: one expectation per driven vector, compared after its edge.
    always @(posedge clock) begin
        #2;
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("level",       e.id, 32'(level),       32'(e.lvl));
            chk("z",           e.id, 32'(z),           32'(e.zz));
            chk("match_count", e.id, 32'(match_count), 32'(e.cnt));
            chk("ovf",         e.id, 32'(ovf),         32'(e.ov));
        end
    end

    task automatic step(input logic [1:0] xi, input logic vi,
                        input logic pw, input logic [1:0] pi, input logic [1:0] ps,
                        input logic lw, input logic [2:0] pl, input logic cl,
                        input int e_lvl, input bit e_z, input int e_cnt, input bit e_ovf);
        exp_t e;
        @(negedge clock);
        x = xi; valid = vi;
        prog_we = pw; prog_idx = pi; prog_sym = ps;
        len_we = lw; prog_len = pl; clear = cl;
        step_id++;
        e.lvl = 3'(e_lvl); e.zz = e_z; e.cnt = 8'(e_cnt); e.ov = e_ovf; e.id = step_id;
        sb.push_back(e);
    endtask

    task automatic sym(input logic [1:0] xi, input int l, input bit ez, input int c);
        step(xi, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 3'd0, 1'b0, l, ez, c, 1'b0);
    endtask

    task automatic idle();
        @(negedge clock);
        x = 2'd0; valid = 1'b0; prog_we = 1'b0; prog_idx = 2'd0; prog_sym = 2'd0;
        len_we = 1'b0; prog_len = 3'd0; clear = 1'b0;
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, ".level"},       0, 32'(level),       32'd0);
        chk({nm, ".z"},           0, 32'(z),           32'd0);
        chk({nm, ".match_count"}, 0, 32'(match_count), 32'd0);
        chk({nm, ".ovf"},         0, 32'(ovf),         32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_ = 1'b0;
        x = 2'd0; valid = 1'b0; prog_we = 1'b0; prog_idx = 2'd0; prog_sym = 2'd0;
        len_we = 1'b0; prog_len = 3'd0; clear = 1'b0;
        #1;
        chk_zero("reset");
        // Inputs must be ignored while reset is held.
        @(negedge clock);
        x = 2'd3; valid = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk_zero("reset_hold");
        idle();
        reset_ = 1'b1;

        // Default sequence 11,01,10 with LEN=3.
        sym(2'd3, 1, 0, 0);
        sym(2'd1, 2, 0, 0);
        sym(2'd2, 3, 1, 1);
        sym(2'd0, 0, 0, 1);

        // Fallback: repeated 11 holds k at 1, mismatch drops to 0.
        sym(2'd3, 1, 0, 1);
        sym(2'd3, 1, 0, 1);
        sym(2'd1, 2, 0, 1);
        sym(2'd0, 0, 0, 1);
        sym(2'd3, 1, 0, 1);
        sym(2'd1, 2, 0, 1);
        sym(2'd2, 3, 1, 2);

        // valid gaps hold k, including in the match state.
        sym(2'd3, 1, 0, 2);
        repeat (3) step(2'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 3'd0, 1'b0, 1, 0, 2, 0);
        sym(2'd1, 2, 0, 2);
        sym(2'd2, 3, 1, 3);
        step(2'd2, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 3'd0, 1'b0, 3, 1, 3, 0);

        // LEN=1: the len_we edge discards x=11; then one match per symbol.
        step(2'd3, 1'b1, 1'b0, 2'd0, 2'd0, 1'b1, 3'd1, 1'b0, 0, 0, 3, 0);
        sym(2'd3, 1, 1, 4);
        sym(2'd3, 1, 1, 5);
        sym(2'd3, 1, 1, 6);
        // prog_we with a matching symbol present: k=0, no count.
        step(2'd3, 1'b1, 1'b1, 2'd0, 2'd3, 1'b0, 3'd0, 1'b0, 0, 0, 6, 0);
        sym(2'd3, 1, 1, 7);

        // Oversized length clamps to DEPTH=4 (sequence 11,01,10,00).
        step(2'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 3'd7, 1'b0, 0, 0, 7, 0);
        sym(2'd3, 1, 0, 7);
        sym(2'd1, 2, 0, 7);
        sym(2'd2, 3, 0, 7);
        sym(2'd0, 4, 1, 8);
        // Zero length is ignored but still drops progress.
        step(2'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 3'd0, 1'b0, 0, 0, 8, 0);
        sym(2'd3, 1, 0, 8);
        sym(2'd1, 2, 0, 8);
        sym(2'd2, 3, 0, 8);
        sym(2'd0, 4, 1, 9);

        // prog_we (slot 2 <- 00) and len_we (3) together: sequence 11,01,00.
        step(2'd0, 1'b0, 1'b1, 2'd2, 2'd0, 1'b1, 3'd3, 1'b0, 0, 0, 9, 0);
        sym(2'd3, 1, 0, 9);
        sym(2'd1, 2, 0, 9);
        sym(2'd0, 3, 1, 10);

        // clear alone, then clear on the same edge as a match.
        step(2'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 3'd0, 1'b1, 3, 1, 0, 0);
        sym(2'd3, 1, 0, 0);
        sym(2'd1, 2, 0, 0);
        step(2'd0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 3'd0, 1'b1, 3, 1, 0, 0);
        sym(2'd3, 1, 0, 0);
        sym(2'd1, 2, 0, 0);
        sym(2'd0, 3, 1, 1);

        // Saturation with LEN=1.
        step(2'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 3'd1, 1'b0, 0, 0, 1, 0);
        for (int i = 2; i <= 255; i++) sym(2'd3, 1, 1, i);
        step(2'd3, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 3'd0, 1'b0, 1, 1, 255, 1);
        step(2'd3, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 3'd0, 1'b0, 1, 1, 255, 1);
        step(2'd3, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 3'd0, 1'b1, 1, 1, 0, 0);
        sym(2'd3, 1, 1, 1);

        // Async reset mid-sequence at k=2 (LEN=3, sequence 11,01,00).
        step(2'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 3'd3, 1'b0, 0, 0, 1, 0);
        sym(2'd3, 1, 0, 1);
        sym(2'd1, 2, 0, 1);
        idle();
        @(posedge clock);
        #3;
        reset_ = 1'b0;
        #1;
        chk_zero("async_reset");
        @(negedge clock);
        x = 2'd3; valid = 1'b1; prog_we = 1'b1; prog_idx = 2'd2; prog_sym = 2'd1;
        len_we = 1'b1; prog_len = 3'd1;
        repeat (2) @(posedge clock);
        #1;
        chk_zero("async_reset_hold");
        idle();
        reset_ = 1'b1;

        // Defaults restored: 11,01,10 matches at LEN=3, then LEN=4 uses slot 3 = 00.
        sym(2'd3, 1, 0, 0);
        sym(2'd1, 2, 0, 0);
        sym(2'd2, 3, 1, 1);
        step(2'd0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 3'd4, 1'b0, 0, 0, 1, 0);
        sym(2'd3, 1, 0, 1);
        sym(2'd1, 2, 0, 1);
        sym(2'd2, 3, 0, 1);
        sym(2'd0, 4, 1, 2);

        idle();
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clock);
        #3;
        chk("scoreboard_drain", 0, 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/config_sequence_detector.md
CONFIG_SEQUENCE_DETECTOR -- requirements
Module: config_sequence_detector

Interface
REQ-001 The block SHALL have the parameter W, default 2, giving the symbol width in bits.
REQ-002 The block SHALL have the parameter DEPTH, default 4, giving the maximum sequence length in symbols.
REQ-003 The block SHALL have the parameter CNT_W, default 8, giving the match counter width.
REQ-004 The block SHALL have the parameter INIT_SEQ, default 8'b00_10_01_11, giving the DEPTH*W-bit reset sequence, with symbol 0 in the LSBs.
REQ-005 The block SHALL have the parameter INIT_LEN, default 3, giving the reset sequence length.
REQ-006 The block SHALL have the port clock  input  1  single clock; all state changes on the posedge.
REQ-007 The block SHALL have the port reset_  input  1  reset, asynchronous and active-low.
REQ-008 The block SHALL have the port x  input  W  the incoming symbol.
REQ-009 The block SHALL have the port valid  input  1  which qualifies x; the symbol is consumed only when valid=1.
REQ-010 The block SHALL have the port prog_we  input  1  a strobe that writes prog_sym into slot prog_idx.
REQ-011 The block SHALL have the port prog_idx  input  clog2(DEPTH)  the slot index for the symbol write.
REQ-012 The block SHALL have the port prog_sym  input  W  the symbol to write.
REQ-013 The block SHALL have the port len_we  input  1  a strobe that writes prog_len into the length register LEN.
REQ-014 The block SHALL have the port prog_len  input  clog2(DEPTH+1)  the new sequence length.
REQ-015 The block SHALL have the port clear  input  1  a synchronous clear of match_count and ovf.
REQ-016 The block SHALL have the port z  output  1  Moore match flag, equal to 1 while the progress state equals LEN.
REQ-017 The block SHALL have the port level  output  clog2(DEPTH+1)  the current progress state k (symbols matched).
REQ-018 The block SHALL have the port match_count  output  CNT_W  a saturating count of matches.
REQ-019 The block SHALL have the port ovf  output  1  a sticky flag set when a match occurs while match_count is all-ones.

Function
REQ-020 The block SHALL hold the sequence SEQ[0..DEPTH-1] and LEN in registers, and only SEQ[0..LEN-1] SHALL take part in matching.
REQ-021 The progress state k SHALL range over 0..LEN, where k=LEN is the match state.
REQ-022 On a clock edge with valid=1 and no programming strobe, the next k SHALL be k+1 if k<LEN and x==SEQ[k]; otherwise 1 if x==SEQ[0]; otherwise 0.
REQ-023 Rule REQ-022 SHALL also apply from the match state: from k=LEN, x==SEQ[0] gives 1 and anything else gives 0.
REQ-024 For LEN=1, repeated SEQ[0] symbols SHALL keep k=1 and count one match per symbol.
REQ-025 On a clock edge with valid=0, k SHALL hold, and so z SHALL hold.
REQ-026 z and level SHALL be decoded from the k register only, with no combinational path from x or valid.
REQ-027 Latency SHALL be one edge: the edge that consumes the last symbol of the sequence SHALL raise z for the following cycle.
REQ-028 match_count SHALL increment by 1 on every edge where valid=1, no programming strobe is active, and the next k equals LEN.
REQ-029 match_count SHALL saturate at 2^CNT_W-1; a further match at saturation SHALL set ovf and leave the count unchanged.
REQ-030 When clear and an increment occur on the same edge, clear SHALL win: match_count=0 and ovf=0.
REQ-031 On a prog_we edge, SEQ[prog_idx] SHALL be set to prog_sym; a write with prog_idx>=DEPTH SHALL be ignored for SEQ.
REQ-032 On a len_we edge, a prog_len value of 0 SHALL be ignored, a value above DEPTH SHALL store DEPTH, and any other value SHALL be stored as given.
REQ-033 Any prog_we or len_we edge SHALL force k to 0, including ignored writes, and the symbol on x in that cycle SHALL be discarded with no count.
REQ-034 prog_we and len_we on the same edge SHALL both take effect.
REQ-035 Programming SHALL NOT alter match_count or ovf.

Reset
REQ-036 reset_=0 SHALL immediately, without waiting for a clock edge, set k=0, z=0, level=0, match_count=0, ovf=0, SEQ=INIT_SEQ and LEN=INIT_LEN.
REQ-037 While reset_=0, all inputs SHALL be ignored.
REQ-038 On the first edge after release, normal operation per REQ-022 SHALL apply.
REQ-039 Assertion of reset_ mid-sequence or mid-match SHALL abandon progress, with no count recorded.

Verification
REQ-040 Defaults: stream 11,01,10 with valid=1 -> level 1,2,3; z=1 for exactly one cycle after the third edge; match_count=1.
REQ-041 Fallback: stream 11,11,01,00,11,01,10 -> level 1,1,2,0,1,2,3; one match; the repeated 11 holds k at 1.
REQ-042 valid gaps: 11, (valid=0 for 3 cycles with x=00), 01, 10 -> z=1 after the last edge; k holds at 1 during the gap.
REQ-043 Reprogramming: len_we with prog_len=1, then stream 11,11,11 -> z stays 1 for three cycles, match_count=3; a prog_we with x=11 on the same edge -> k=0 and no count.
REQ-044 Saturation: CNT_W=2, five matches -> match_count=3, ovf=1; clear together with a match on the same edge -> 0,0.
REQ-045 Async reset: pull reset_ low between clock edges at k=2 with match_count=5 -> all outputs 0 before the next edge; after release, SEQ and LEN are back to the defaults.
